// File: rtl/game_ctrl.sv
// Whack-a-mole round sequencer: lights one LFSR-chosen mole per round, scores hits,
// and paces rounds with an external countdown timer.
module game_ctrl #(
  parameter int         NUM_MOLES = 4,
  parameter int         ROUNDS    = 8,
  parameter int         SCORE_W   = 4,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_MOLES-1:0] btn,
  input  logic                 timer_running,
  input  logic                 timer_timeout,
  output logic                 timer_load,
  output logic [NUM_MOLES-1:0] mole,
  output logic [SCORE_W-1:0]   score,
  output logic [3:0]           round,
  output logic                 busy,
  output logic                 done
);

  localparam int                 IDX_W      = $clog2(NUM_MOLES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
  localparam logic [3:0]         ROUND_LAST = 4'(ROUNDS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ARM    = 3'd2,
    ACTIVE = 3'd3,
    GAP    = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t               state_r, state_s;
  logic [7:0]           lfsr_r;
  logic [IDX_W-1:0]     idx_r;
  logic [SCORE_W-1:0]   score_r, score_s;
  logic [3:0]           round_r, round_s;
  logic [NUM_MOLES-1:0] mole_s;
  logic                 hit_s;

  // x^8+x^6+x^5+x^4+1 Fibonacci step; a non-zero state never maps to zero
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Lit mole is decoded from registered state and index only
  always_comb begin
    mole_s = '0;
    if (state_r == ACTIVE) begin
      mole_s = NUM_MOLES'(1) << idx_r;
    end else begin
      mole_s = '0;
    end
  end

  assign hit_s = |(btn & mole_s);

  // Next-state, score and round logic
  always_comb begin
    state_s = state_r;
    score_s = score_r;
    round_s = round_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          score_s = '0;
          round_s = 4'd0;
          state_s = LOAD;
        end else begin
          state_s = state_r;
        end
      end
      LOAD: state_s = ARM;
      ARM: begin
        // timeout is stale here until the reload takes effect, so only running matters
        if (timer_running) begin
          state_s = ACTIVE;
        end else begin
          state_s = ARM;
        end
      end
      ACTIVE: begin
        if (hit_s) begin
          state_s = GAP;
          if (score_r != SCORE_MAX) begin
            score_s = score_r + SCORE_ONE;
          end else begin
            score_s = score_r;
          end
        end else if ((btn != '0) || timer_timeout) begin
          state_s = GAP;
        end else begin
          state_s = ACTIVE;
        end
      end
      GAP: begin
        if (round_r == ROUND_LAST) begin
          state_s = DONE;
        end else begin
          round_s = round_r + 4'd1;
          state_s = LOAD;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, score, round and mole index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      score_r <= '0;
      round_r <= 4'd0;
      idx_r   <= '0;
    end else begin
      state_r <= state_s;
      score_r <= score_s;
      round_r <= round_s;
      if (state_r == LOAD) begin
        idx_r <= lfsr_r[IDX_W-1:0];
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  // Free-running mole selector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  assign timer_load = (state_r == LOAD);
  assign mole       = mole_s;
  assign score      = score_r;
  assign round      = round_r;
  assign busy       = (state_r != IDLE) && (state_r != DONE);
  assign done       = (state_r == DONE);

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with a behavioural countdown timer; a second
// instance with a 2-bit score runs in lockstep to observe saturation.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] btn = 4'd0;
  logic       timer_running = 1'b0;
  logic       timer_timeout = 1'b0;
  logic       timer_load;
  logic [3:0] mole;
  logic [3:0] score;
  logic [3:0] round;
  logic       busy;
  logic       done;

  logic       timer_load2;
  logic [3:0] mole2;
  logic [1:0] score2;
  logic [3:0] round2;
  logic       busy2;
  logic       done2;

  int errors = 0;
  int checks = 0;

  game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .btn(btn),
    .timer_running(timer_running), .timer_timeout(timer_timeout),
    .timer_load(timer_load), .mole(mole), .score(score), .round(round),
    .busy(busy), .done(done)
  );

  game_ctrl #(.SCORE_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .btn(btn),
    .timer_running(timer_running), .timer_timeout(timer_timeout),
    .timer_load(timer_load2), .mole(mole2), .score(score2), .round(round2),
    .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  // Behavioural timer: running the cycle after load (or after tm_delay extra cycles),
  // timeout after tm_n cycles of running, timeout held until the next load
  int   tm_n = 20;
  int   tm_delay = 0;
  int   cnt = 0;
  int   dly = 0;
  logic armed = 1'b0;
  always @(posedge clk) begin
    if (timer_load) begin
      cnt <= tm_n;
      if (tm_delay == 0) begin
        timer_running <= 1'b1; timer_timeout <= 1'b0; armed <= 1'b0;
      end else begin
        dly <= tm_delay - 1; armed <= 1'b1; timer_running <= 1'b0;
      end
    end else if (armed) begin
      if (dly == 0) begin
        timer_running <= 1'b1; timer_timeout <= 1'b0; armed <= 1'b0;
      end else begin
        dly <= dly - 1;
      end
    end else if (timer_running) begin
      if (cnt == 1) begin
        timer_running <= 1'b0; timer_timeout <= 1'b1;
      end
      cnt <= cnt - 1;
    end
  end

  // Reference LFSR and the mole index expected to be latched at each LOAD
  logic [7:0] m_lfsr;
  logic [1:0] lat_idx = 2'd0;
  int         n_loads = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end
  always @(posedge clk) begin
    if (timer_load) begin
      lat_idx <= m_lfsr[1:0];
      n_loads <= n_loads + 1;
    end
  end

  int         r_lit;
  logic [3:0] r_rnd;
  bit         r_dark;
  bit         r_to;

  // mode: 0 correct hit, 1 no press, 2 wrong bit, 3 correct on timeout, 4 correct+wrong
  task automatic play_round(input int mode);
    int   wait_n = 0;
    bit   pressed = 0;
    logic [3:0] good, bad;
    while (mole == 4'd0 && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    good = 4'd1 << lat_idx;
    bad  = 4'd1 << (lat_idx + 2'd1);
    checks++;
    if (mole !== good) begin
      errors++;
      $display("FAIL mole_lit: got %b expected %b", mole, good);
    end
    r_rnd = round; r_lit = 0; r_dark = 0; r_to = 0;
    while (mole != 4'd0 && r_lit < 200) begin
      r_lit++;
      if (!pressed && (mode == 0 || mode == 2 || mode == 4 || (mode == 3 && timer_timeout))) begin
        btn = (mode == 2) ? bad : ((mode == 4) ? (good | bad) : good);
        r_to = timer_timeout;
        pressed = 1;
        @(negedge clk);
        btn = 4'd0;
        r_dark = (mole == 4'd0);
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    int l0;
    #2;
    checks++;
    if ({score, round, mole, timer_load, busy, done} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0", {score, round, mole, timer_load, busy, done});
    end
    @(negedge clk); rst_n = 1'b1;
    l0 = n_loads;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || n_loads != l0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b loads=%0d expected busy=0 loads=0", busy, n_loads - l0);
    end
  endtask

  task automatic test_all_hits();
    int l0;
    tm_n = 20;
    l0 = n_loads;
    pulse_start();
    checks++;
    if (timer_load !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: timer_load=%b busy=%b expected 1 1", timer_load, busy);
    end
    for (int r = 0; r < 8; r++) begin
      play_round(0);
      checks++;
      if (r_rnd !== 4'(r) || score !== 4'(r + 1) || !r_dark) begin
        errors++;
        $display("FAIL hit_round%0d: round=%0d score=%0d dark=%0d expected %0d %0d 1", r, r_rnd, score, r_dark, r, r + 1);
      end
      if (r == 0) begin
        @(negedge clk);
        checks++;
        if (timer_load !== 1'b1) begin
          errors++;
          $display("FAIL hit_to_load: timer_load=%b expected 1", timer_load);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || mole !== 4'd0 || score !== 4'd8 || round !== 4'd7) begin
      errors++;
      $display("FAIL all_hits_end: done=%b busy=%b mole=%b score=%0d round=%0d expected 1 0 0000 8 7",
               done, busy, mole, score, round);
    end
    checks++;
    if (n_loads - l0 != 8) begin
      errors++;
      $display("FAIL load_count: got %0d expected 8", n_loads - l0);
    end
    checks++;
    if (score2 !== 2'd3 || done2 !== 1'b1) begin
      errors++;
      $display("FAIL score_saturate: got %0d done=%b expected 3 done=1", score2, done2);
    end
  endtask

  task automatic test_timeouts();
    tm_n = 20;
    pulse_start();
    for (int r = 0; r < 8; r++) begin
      play_round(1);
      checks++;
      if (r_lit != 20 || score !== 4'd0) begin
        errors++;
        $display("FAIL timeout_round%0d: lit=%0d score=%0d expected 20 0", r, r_lit, score);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || score !== 4'd0 || mole !== 4'd0) begin
      errors++;
      $display("FAIL timeouts_end: done=%b score=%0d mole=%b expected 1 0 0000", done, score, mole);
    end
  endtask

  task automatic test_wrong_press();
    tm_n = 20;
    pulse_start();
    play_round(2);
    checks++;
    if (!r_dark || score !== 4'd0) begin
      errors++;
      $display("FAIL wrong_press: dark=%0d score=%0d expected 1 0", r_dark, score);
    end
    play_round(4);
    checks++;
    if (score !== 4'd1) begin
      errors++;
      $display("FAIL mixed_press: score=%0d expected 1", score);
    end
    for (int r = 2; r < 8; r++) play_round(0);
    @(negedge clk);
    checks++;
    if (score !== 4'd7 || done !== 1'b1) begin
      errors++;
      $display("FAIL wrong_press_end: score=%0d done=%b expected 7 1", score, done);
    end
  endtask

  task automatic test_stale_timeout();
    tm_n = 5;
    tm_delay = 0;
    pulse_start();
    play_round(1);
    tm_delay = 3;
    @(negedge clk);
    checks++;
    if (timer_load !== 1'b1) begin
      errors++;
      $display("FAIL stale_load: timer_load=%b expected 1", timer_load);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tm_delay = 0;
      checks++;
      if (mole !== 4'd0 || busy !== 1'b1 || score !== 4'd0) begin
        errors++;
        $display("FAIL stale_arm%0d: mole=%b busy=%b score=%0d expected 0000 1 0", i, mole, busy, score);
      end
    end
    play_round(3);
    checks++;
    if (r_lit != 5 || !r_to || score !== 4'd1) begin
      errors++;
      $display("FAIL hit_with_timeout: lit=%0d to=%0d score=%0d expected 5 1 1", r_lit, r_to, score);
    end
    for (int r = 2; r < 8; r++) play_round(0);
    @(negedge clk);
    checks++;
    if (score !== 4'd7 || done !== 1'b1) begin
      errors++;
      $display("FAIL stale_end: score=%0d done=%b expected 7 1", score, done);
    end
  endtask

  task automatic test_reset_mid();
    int wait_n = 0;
    int l0;
    tm_n = 20;
    pulse_start();
    for (int r = 0; r < 3; r++) play_round(0);
    while (mole == 4'd0 && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    checks++;
    if (round !== 4'd3 || mole === 4'd0) begin
      errors++;
      $display("FAIL mid_round3: round=%0d mole=%b expected 3 lit", round, mole);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({score, round, mole, timer_load, busy, done} !== 15'd0 || score2 !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: got %b expected 0", {score, round, mole, timer_load, busy, done});
    end
    @(negedge clk); rst_n = 1'b1;
    l0 = n_loads;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || n_loads != l0) begin
      errors++;
      $display("FAIL wait_for_start: busy=%b loads=%0d expected 0 0", busy, n_loads - l0);
    end
    pulse_start();
    checks++;
    if (timer_load !== 1'b1 || score !== 4'd0 || round !== 4'd0) begin
      errors++;
      $display("FAIL restart: load=%b score=%0d round=%0d expected 1 0 0", timer_load, score, round);
    end
    play_round(0);
    checks++;
    if (score !== 4'd1 || r_rnd !== 4'd0) begin
      errors++;
      $display("FAIL restart_hit: score=%0d round=%0d expected 1 0", score, r_rnd);
    end
  endtask

  initial begin
    test_reset();
    test_all_hits();
    test_timeouts();
    test_wrong_press();
    test_stale_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_MOLES, default 4, number of mole positions; power of two, 2..8.
REQ-002 The block SHALL have parameter ROUNDS, default 8, moles presented per game; 1..15.
REQ-003 The block SHALL have parameter SCORE_W, default 4, score counter width.
REQ-004 The block SHALL have parameter LFSR_SEED, default 8'hA5, non-zero LFSR reset value.
REQ-005 The block SHALL have port clk, input, 1, sole clock; all state is updated on the rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1, one-cycle game start request.
REQ-008 The block SHALL have port btn, input, NUM_MOLES, synchronized one-cycle hit pulses, one bit per mole.
REQ-009 The block SHALL have port timer_running, input, 1, countdown timer running flag.
REQ-010 The block SHALL have port timer_timeout, input, 1, timer expired flag; held high until the next load.
REQ-011 The block SHALL have port timer_load, output, 1, one-cycle pulse that (re)starts the timer from any state.
REQ-012 The block SHALL have port mole, output, NUM_MOLES, one-hot lit mole, or all zero.
REQ-013 The block SHALL have port score, output, SCORE_W, hits in the current game.
REQ-014 The block SHALL have port round, output, 4, index of the current round, 0..ROUNDS-1.
REQ-015 The block SHALL have port busy, output, 1, high in every state other than IDLE and DONE.
REQ-016 The block SHALL have port done, output, 1, high in DONE.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, ARM, ACTIVE, GAP and DONE.
REQ-018 In IDLE or DONE, start=1 SHALL clear score and round and transition to LOAD; start SHALL be ignored in every other state.
REQ-019 LOAD SHALL assert timer_load for exactly one cycle, latch the mole index, and transition to ARM.
REQ-020 The latched mole index SHALL be the low log2(NUM_MOLES) bits of the LFSR value at that edge.
REQ-021 ARM SHALL wait for timer_running=1 and then transition to ACTIVE; timer_timeout SHALL be ignored in ARM, because it is stale until the timer reloads.
REQ-022 mole SHALL be one-hot of the latched index in ACTIVE only, and all zero in every other state.
REQ-023 In ACTIVE, if (btn & mole) != 0, the block SHALL count a hit: score increments, saturating at 2^SCORE_W-1, and the FSM goes to GAP.
REQ-024 In ACTIVE, if btn != 0 and (btn & mole) == 0, the block SHALL count a miss: score is unchanged and the FSM goes to GAP.
REQ-025 In ACTIVE, if btn == 0 and timer_timeout == 1, the block SHALL count a miss and go to GAP.
REQ-026 When a correct hit and timer_timeout occur in the same cycle, the hit SHALL win; when a correct and a wrong bit are pressed together, the press SHALL count as a hit.
REQ-027 GAP SHALL last one cycle: if round == ROUNDS-1 it goes to DONE with round held, otherwise round increments and it goes to LOAD.
REQ-028 The timer SHALL NOT be stopped after a hit; the next LOAD reload restarts it.
REQ-029 The LFSR SHALL be 8-bit Fibonacci with taps x^8+x^6+x^5+x^4+1, advance every cycle in every state, and never reach zero.
REQ-030 All outputs SHALL be registered or decoded from the state register only, with no combinational path from inputs to outputs.
REQ-031 Latency SHALL be: start to timer_load = 1 cycle; timer_running to mole lit = 1 cycle; hit to score update = 1 cycle; hit to next timer_load = 2 cycles.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state to IDLE, score to 0, round to 0, mole to 0, timer_load to 0, busy to 0, done to 0, and the LFSR to LFSR_SEED.
REQ-033 Reset in any state mid-game SHALL abandon the game; on release the block SHALL wait in IDLE for start and issue no timer_load.

Verification
(Bench uses a behavioural timer: running=1 the cycle after load, timeout after N cycles.)
REQ-034 Defaults, start, every round hit correctly before timeout -> 8 timer_load pulses; score=8 (saturating at 15 is not reached); done=1; busy=0; mole=0.
REQ-035 start with no button presses, N=20 -> each round ends on timeout; score=0; done after 8 timeouts; mole lit 20 cycles per round.
REQ-036 Wrong bit pressed in round 0, correct hits thereafter -> score=7; round-0 mole goes dark on the cycle after the press.
REQ-037 Correct hit coincident with timer_timeout -> score increments; a stale timeout=1 present during ARM does not end the next round.
REQ-038 SCORE_W=2, 8 hits -> score saturates at 3.
REQ-039 rst_n pulsed low during round 3 ACTIVE -> all outputs reach reset values without a clock edge; start is then required; a new game begins with score=0 and round=0.
